// File: rtl/demux_pkg.sv
// Shared types and helpers for the packet-aware 1-to-N stream demultiplexer.
package demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } demux_state_e;

    // Width of a destination index for n outputs (at least one bit).
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready holding register carrying {data, last} for a single output lane.
module demux_lane_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;

    // A load wins over a drain so a simultaneous drain+load replaces the beat without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/demux_n_stream.sv
// Packet-aware 1-to-N valid/ready demultiplexer: destination latched on the first beat, held to s_last.
module demux_n_stream
    import demux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = sel_width(N)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH-1:0]          s_data,
    input  logic [SEL_W-1:0]          s_sel,
    input  logic                      s_last,
    output logic [N-1:0]              m_valid,
    input  logic [N-1:0]              m_ready,
    output logic [N-1:0][WIDTH-1:0]   m_data,
    output logic [N-1:0]              m_last,
    output logic                      err_drop
);

    demux_state_e     r_state;
    demux_state_e     w_state_nxt;
    logic [SEL_W-1:0] r_dest;
    logic [SEL_W-1:0] w_dest;
    logic             w_dest_ok;
    logic             w_busy;
    logic             w_accept;
    logic [N-1:0]     w_load;

    assign w_dest    = (r_state == PKT) ? r_dest : s_sel;
    assign w_dest_ok = (int'(w_dest) < N);

    // Out-of-range destinations match no lane, so they are never busy and always accepted.
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_dest == SEL_W'(i)) begin
                w_busy = m_valid[i] && !m_ready[i];
            end
        end
    end

    assign s_ready  = rst_n && !w_busy;
    assign w_accept = s_valid && s_ready;
    assign err_drop = w_accept && !w_dest_ok;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < N; i++) begin
            if (w_dest == SEL_W'(i)) begin
                w_load[i] = w_accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dest  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_accept && !s_last) begin
                r_dest <= s_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept && !s_last) w_state_nxt = PKT;
            PKT:  if (w_accept && s_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        demux_lane_reg #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_data  (s_data),
            .i_last  (s_last),
            .i_ready (m_ready[g]),
            .o_valid (m_valid[g]),
            .o_data  (m_data[g]),
            .o_last  (m_last[g])
        );
    end

endmodule

// File: tb/tb_demux_n_stream.sv
// Self-checking bench for demux_n_stream: vector table, directed corner sequences, random vs. queue model.
module tb_demux_n_stream;

    logic             clk;
    logic             rst_n;

    // N=4 instance
    logic             s_valid;
    logic             s_ready;
    logic [3:0]       s_data;
    logic [1:0]       s_sel;
    logic             s_last;
    logic [3:0]       m_valid;
    logic [3:0]       m_ready;
    logic [3:0][3:0]  m_data;
    logic [3:0]       m_last;
    logic             err_drop;

    // N=3 instance, exercises out-of-range destination
    logic             s3_valid;
    logic             s3_ready;
    logic [3:0]       s3_data;
    logic [1:0]       s3_sel;
    logic             s3_last;
    logic [2:0]       m3_valid;
    logic [2:0]       m3_ready;
    logic [2:0][3:0]  m3_data;
    logic [2:0]       m3_last;
    logic             err3_drop;

    int n_checks;
    int n_errors;

    demux_n_stream #(.N(4), .WIDTH(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sel    (s_sel),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .err_drop (err_drop)
    );

    demux_n_stream #(.N(3), .WIDTH(4)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s3_valid),
        .s_ready  (s3_ready),
        .s_data   (s3_data),
        .s_sel    (s3_sel),
        .s_last   (s3_last),
        .m_valid  (m3_valid),
        .m_ready  (m3_ready),
        .m_data   (m3_data),
        .m_last   (m3_last),
        .err_drop (err3_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
        logic [3:0] exp_valid;
    } vec_t;

    vec_t vecs[4];

    // Reference model state for the random phase
    logic [4:0] exp_q[4][$];
    bit         pkt_open;
    int         pkt_dest;
    int         d;
    logic       exp_rdy;
    logic [3:0] exp_valid_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] data, input logic last);
        s_valid = v;
        s_sel   = sel;
        s_data  = data;
        s_last  = last;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{sel: 2'd0, data: 4'b0001, exp_valid: 4'b0001};
        vecs[1] = '{sel: 2'd1, data: 4'b0010, exp_valid: 4'b0010};
        vecs[2] = '{sel: 2'd2, data: 4'b0100, exp_valid: 4'b0100};
        vecs[3] = '{sel: 2'd3, data: 4'b1000, exp_valid: 4'b1000};

        rst_n    = 1'b0;
        drive(1'b1, 2'd0, 4'h0, 1'b1);
        m_ready  = 4'hF;
        s3_valid = 1'b0;
        s3_sel   = 2'd0;
        s3_data  = 4'h0;
        s3_last  = 1'b0;
        m3_ready = 3'b111;
        #1;
        check("reset_s_ready", s_ready, 1'b0);
        step();
        step();
        check("reset_m_valid", m_valid, 4'h0);
        check("reset_m_last", m_last, 4'h0);
        check("reset_m_data", m_data, 16'h0);
        check("reset_err_drop", err_drop, 1'b0);
        check("reset_s_ready_held", s_ready, 1'b0);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        step();

        // Single-beat routing, back to back
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vecs[i].sel, vecs[i].data, 1'b1);
            #1;
            check("route_ready", s_ready, 1'b1);
            step();
            check("route_valid", m_valid, vecs[i].exp_valid);
            check("route_data", m_data[vecs[i].sel], vecs[i].data);
            check("route_last", m_last, vecs[i].exp_valid);
        end
        s_valid = 1'b0;
        step();
        check("route_drained", m_valid, 4'h0);

        // Packet lock: sel changes mid-packet are ignored
        drive(1'b1, 2'd2, 4'hA, 1'b0);
        step();
        check("lock_v0", m_valid, 4'b0100);
        check("lock_d0", m_data[2], 4'hA);
        check("lock_l0", m_last, 4'b0000);
        drive(1'b1, 2'd1, 4'hB, 1'b0);
        step();
        check("lock_v1", m_valid, 4'b0100);
        check("lock_d1", m_data[2], 4'hB);
        drive(1'b1, 2'd1, 4'hC, 1'b1);
        step();
        check("lock_v2", m_valid, 4'b0100);
        check("lock_d2", m_data[2], 4'hC);
        check("lock_l2", m_last, 4'b0100);
        s_valid = 1'b0;
        step();

        // Backpressure on port 1
        m_ready = 4'b1101;
        drive(1'b1, 2'd1, 4'h5, 1'b1);
        step();
        check("bp_v0", m_valid, 4'b0010);
        check("bp_d0", m_data[1], 4'h5);
        drive(1'b1, 2'd1, 4'h6, 1'b1);
        #1;
        check("bp_ready_low", s_ready, 1'b0);
        step();
        step();
        check("bp_hold_d", m_data[1], 4'h5);
        check("bp_hold_v", m_valid, 4'b0010);
        check("bp_ready_still_low", s_ready, 1'b0);
        m_ready = 4'hF;
        #1;
        check("bp_ready_up", s_ready, 1'b1);
        step();
        check("bp_d1", m_data[1], 4'h6);
        check("bp_v1", m_valid, 4'b0010);
        s_valid = 1'b0;
        step();
        check("bp_drained", m_valid, 4'h0);

        // Independent drain: port 0 stalled, packet to port 3 flows
        m_ready = 4'b1110;
        drive(1'b1, 2'd0, 4'h9, 1'b1);
        step();
        check("ind_p0", m_valid, 4'b0001);
        drive(1'b1, 2'd3, 4'hA, 1'b0);
        #1;
        check("ind_ready", s_ready, 1'b1);
        step();
        check("ind_v0", m_valid, 4'b1001);
        check("ind_d3a", m_data[3], 4'hA);
        check("ind_d0a", m_data[0], 4'h9);
        drive(1'b1, 2'd3, 4'hB, 1'b1);
        step();
        check("ind_v1", m_valid, 4'b1001);
        check("ind_d3b", m_data[3], 4'hB);
        check("ind_l3", m_last, 4'b1001);
        s_valid = 1'b0;
        step();
        check("ind_p0_kept", m_valid, 4'b0001);
        check("ind_d0_kept", m_data[0], 4'h9);
        m_ready = 4'hF;
        step();
        check("ind_drained", m_valid, 4'h0);

        // Reset in the middle of a 4-beat packet to port 2
        drive(1'b1, 2'd2, 4'h1, 1'b0);
        step();
        drive(1'b1, 2'd2, 4'h2, 1'b0);
        step();
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("mid_rst_ready", s_ready, 1'b0);
        step();
        check("mid_rst_valid", m_valid, 4'h0);
        check("mid_rst_data", m_data, 16'h0);
        check("mid_rst_last", m_last, 4'h0);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 4'h3, 1'b0);
        #1;
        check("post_rst_ready", s_ready, 1'b1);
        step();
        check("post_rst_v0", m_valid, 4'b0001);
        check("post_rst_d0", m_data[0], 4'h3);
        drive(1'b1, 2'd2, 4'h4, 1'b1);
        step();
        check("post_rst_v1", m_valid, 4'b0001);
        check("post_rst_d1", m_data[0], 4'h4);
        check("post_rst_l1", m_last, 4'b0001);
        s_valid = 1'b0;
        step();

        // Out-of-range destination on the N=3 instance
        s3_valid = 1'b1; s3_sel = 2'd3; s3_data = 4'h7; s3_last = 1'b0;
        #1;
        check("oor_ready0", s3_ready, 1'b1);
        check("oor_err0", err3_drop, 1'b1);
        step();
        check("oor_v0", m3_valid, 3'b000);
        s3_sel = 2'd0; s3_data = 4'h8; s3_last = 1'b1;
        #1;
        check("oor_ready1", s3_ready, 1'b1);
        check("oor_err1", err3_drop, 1'b1);
        step();
        check("oor_v1", m3_valid, 3'b000);
        s3_sel = 2'd0; s3_data = 4'h9; s3_last = 1'b1;
        #1;
        check("oor_err_clear", err3_drop, 1'b0);
        step();
        check("oor_next_v", m3_valid, 3'b001);
        check("oor_next_d", m3_data[0], 4'h9);
        s3_valid = 1'b0;
        step();

        // Random traffic against the per-port queue model
        pkt_open = 1'b0;
        pkt_dest = 0;
        for (int c = 0; c < 400; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_sel   = 2'($urandom_range(0, 3));
            s_data  = 4'($urandom);
            s_last  = ($urandom_range(0, 2) == 0);
            m_ready = 4'($urandom) | 4'($urandom);
            #1;
            d = pkt_open ? pkt_dest : int'(s_sel);
            exp_rdy = (exp_q[d].size() == 0) || m_ready[d];
            check("rand_ready", s_ready, exp_rdy);
            exp_valid_v = 4'h0;
            for (int p = 0; p < 4; p++) begin
                if (exp_q[p].size() != 0) exp_valid_v[p] = 1'b1;
            end
            check("rand_valid", m_valid, exp_valid_v);
            for (int p = 0; p < 4; p++) begin
                if (exp_q[p].size() != 0) begin
                    check("rand_beat", {m_last[p], m_data[p]}, exp_q[p][0]);
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (m_ready[p] && exp_q[p].size() != 0) void'(exp_q[p].pop_front());
            end
            if (s_valid && exp_rdy) begin
                exp_q[d].push_back({s_last, s_data});
                if (!pkt_open && !s_last) begin
                    pkt_open = 1'b1;
                    pkt_dest = int'(s_sel);
                end else if (pkt_open && s_last) begin
                    pkt_open = 1'b0;
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
